// File: rtl/disparity_hole_fill.sv
// disparity_hole_fill: one streaming hole-filling pass over a disparity frame.
// Walks the frame via an external address calculator, reads each pixel from
// BRAM, and writes the filtered value to the output BRAM at the same address.
// Short runs of zero (invalid) disparities are replaced by the last valid
// value of the same line; longer runs keep their unfilled tail.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for start; fill_count holds the last frame's result
//   RUN   | one read per cycle, addresses from the calculator
//   DRAIN | reads stopped, in-flight pixels are filtered and written
//   DONE  | one-cycle done pulse, then back to IDLE
module disparity_hole_fill #(
  parameter int WIDTH      = 120,
  parameter int HEIGHT     = 240,
  parameter int ADDR_W     = $clog2(WIDTH*HEIGHT),
  parameter int DISP_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int MAX_GAP    = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              vertical_in,
  output logic              busy,
  output logic              done,
  output logic              addr_go,
  output logic              addr_vertical,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              line_first_in,
  input  logic              line_last_in,
  input  logic              frame_last_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DISP_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DISP_W-1:0] wr_data,
  output logic [ADDR_W:0]   fill_count
);

  localparam int         LAST    = RD_LATENCY - 1;
  localparam int         CNT_W   = $clog2(RD_LATENCY + 1) + 1;
  localparam logic [7:0] GAP_MAX = 8'(MAX_GAP);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      drain_cnt_q;
  logic                  vertical_q;
  logic [ADDR_W:0]       fill_count_q;

  logic [RD_LATENCY-1:0] vld_q, lf_q, ll_q;
  logic [ADDR_W-1:0]     pa_q [RD_LATENCY];

  logic                  have_valid_q, have_valid_d, hv_cur;
  logic [DISP_W-1:0]     last_val_q, last_val_d, pix_d;
  logic [7:0]            gap_q, gap_d, gap_cur;
  logic                  fill_inc;

  logic                  wr_en_q;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DISP_W-1:0]     wr_data_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; start outside IDLE is simply not looked at
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)              state_d = S_RUN;
      S_RUN:   if (frame_last_in)      state_d = S_DRAIN;
      S_DRAIN: if (drain_cnt_q == '0)  state_d = S_DONE;
      S_DONE:                          state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the read address is a straight pass-through of the calculator
  always_comb begin
    busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
    done    = (state_q == S_DONE);
    addr_go = (state_q == S_RUN);
    rd_en   = (state_q == S_RUN);
    rd_addr = addr_in;
  end

  // Frame control: direction latched at start, drain down-counter covers the read pipeline plus filter stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vertical_q  <= 1'b0;
      drain_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && start)
        vertical_q <= vertical_in;
      if (state_q == S_RUN && frame_last_in)
        drain_cnt_q <= CNT_W'(RD_LATENCY);
      else if (state_q == S_DRAIN && drain_cnt_q != '0)
        drain_cnt_q <= drain_cnt_q - 1'b1;
    end
  end

  // Read delay line: valid, address and line flags travel with each read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q <= '0;
      lf_q  <= '0;
      ll_q  <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pa_q[i] <= '0;
    end else begin
      vld_q[0] <= rd_en;
      lf_q[0]  <= line_first_in;
      ll_q[0]  <= line_last_in;
      pa_q[0]  <= addr_in;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lf_q[i]  <= lf_q[i-1];
        ll_q[i]  <= ll_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end
    end
  end

  // Filter decision for the pixel returning from BRAM this cycle
  always_comb begin
    hv_cur       = have_valid_q & ~lf_q[LAST];
    gap_cur      = lf_q[LAST] ? 8'd0 : gap_q;
    pix_d        = '0;
    last_val_d   = last_val_q;
    have_valid_d = hv_cur;
    gap_d        = gap_cur;
    fill_inc     = 1'b0;
    if (rd_data != '0) begin
      pix_d        = rd_data;
      last_val_d   = rd_data;
      have_valid_d = 1'b1;
      gap_d        = 8'd0;
    end else if (hv_cur && gap_cur < GAP_MAX) begin
      pix_d    = last_val_q;
      gap_d    = gap_cur + 8'd1;
      fill_inc = 1'b1;
    end else begin
      gap_d = GAP_MAX;
    end
    // Closing the line here as well keeps fills from leaking even if a line_first flag is missed
    if (ll_q[LAST]) begin
      have_valid_d = 1'b0;
      gap_d        = 8'd0;
    end
  end

  // Filter state, write port and saturating fill counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      have_valid_q <= 1'b0;
      last_val_q   <= '0;
      gap_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      fill_count_q <= '0;
    end else begin
      wr_en_q <= vld_q[LAST];
      if (vld_q[LAST]) begin
        have_valid_q <= have_valid_d;
        last_val_q   <= last_val_d;
        gap_q        <= gap_d;
        wr_addr_q    <= pa_q[LAST];
        wr_data_q    <= pix_d;
      end
      if (state_q == S_IDLE && start)
        fill_count_q <= '0;
      else if (vld_q[LAST] && fill_inc && !(&fill_count_q))
        fill_count_q <= fill_count_q + 1'b1;
    end
  end

  assign addr_vertical = vertical_q;
  assign wr_en         = wr_en_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign fill_count    = fill_count_q;

endmodule

// File: tb/tb_disparity_hole_fill.sv
// Testbench for disparity_hole_fill: 8x4 frame, read latency 2, max gap 2.
// Contains an address calculator, a latency-2 source BRAM and a per-line
// reference model of the hole-filling rule.
module tb_disparity_hole_fill;

  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);
  localparam int DW = 8;
  localparam int L  = 2;
  localparam int MG = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          vertical_in = 1'b0;
  logic          busy, done, addr_go, addr_vertical;
  logic [AW-1:0] addr_in;
  logic          line_first_in, line_last_in, frame_last_in;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW:0]   fill_count;

  disparity_hole_fill #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .DISP_W(DW), .RD_LATENCY(L), .MAX_GAP(MG)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .vertical_in(vertical_in),
    .busy(busy), .done(done), .addr_go(addr_go), .addr_vertical(addr_vertical),
    .addr_in(addr_in), .line_first_in(line_first_in), .line_last_in(line_last_in),
    .frame_last_in(frame_last_in), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .fill_count(fill_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Address calculator: linear position, mapped to row/column by direction
  int pos;
  int calc_r, calc_c;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)    pos <= 0;
    else if (addr_go) pos <= (pos == N - 1) ? 0 : pos + 1;
  end
  always_comb begin
    calc_r = 0;
    calc_c = 0;
    if (addr_vertical) begin
      calc_c = pos / H;
      calc_r = pos % H;
    end else begin
      calc_r = pos / W;
      calc_c = pos % W;
    end
    addr_in       = AW'(calc_r * W + calc_c);
    line_first_in = addr_vertical ? (calc_r == 0) : (calc_c == 0);
    line_last_in  = addr_vertical ? (calc_r == H - 1) : (calc_c == W - 1);
    frame_last_in = (pos == N - 1);
  end

  // Source BRAM with L cycles of read latency
  logic [DW-1:0] mem [N];
  logic [DW-1:0] rdq [L];
  always @(posedge clk) begin
    rdq[0] <= rd_en ? mem[rd_addr] : '0;
    for (int i = 1; i < L; i++) rdq[i] <= rdq[i-1];
  end
  assign rd_data = rdq[L-1];

  // Bus monitor
  int   wr_a[$], wr_d[$], wr_c[$], rd_a[$], rd_c[$], done_c[$];
  int   vert_bad = 0;
  logic mon_vert = 1'b0;
  always @(negedge clk) begin
    if (wr_en) begin
      wr_a.push_back(int'(wr_addr));
      wr_d.push_back(int'(wr_data));
      wr_c.push_back(cyc);
    end
    if (rd_en) begin
      rd_a.push_back(int'(rd_addr));
      rd_c.push_back(cyc);
    end
    if (done) done_c.push_back(cyc);
    if (busy && addr_vertical != mon_vert) vert_bad++;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: walk each line in scan order and apply the fill rule
  int exp_a[$], exp_d[$];
  int exp_fill;
  function automatic void build_expected(input bit vert);
    int nlines, llen, a, p, last, run;
    exp_a.delete();
    exp_d.delete();
    exp_fill = 0;
    nlines = vert ? W : H;
    llen   = vert ? H : W;
    for (int ln = 0; ln < nlines; ln++) begin
      last = -1;
      run  = 0;
      for (int j = 0; j < llen; j++) begin
        a = vert ? (j * W + ln) : (ln * W + j);
        p = int'(mem[a]);
        exp_a.push_back(a);
        if (p != 0) begin
          exp_d.push_back(p);
          last = p;
          run  = 0;
        end else if (last >= 0 && run < MG) begin
          exp_d.push_back(last);
          run++;
          exp_fill++;
        end else begin
          exp_d.push_back(0);
        end
      end
    end
  endfunction

  function automatic int rand_pix();
    return ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 255));
  endfunction

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = DW'(rand_pix());
  endtask

  task automatic clear_mon();
    wr_a.delete(); wr_d.delete(); wr_c.delete();
    rd_a.delete(); rd_c.delete(); done_c.delete();
    vert_bad = 0;
  endtask

  // Runs one frame; disturb pulses start and flips vertical_in mid-frame
  task automatic run_frame(input string tag, input bit vert, input bit disturb);
    int t0, k;
    int n;
    build_expected(vert);
    @(negedge clk);
    clear_mon();
    mon_vert    = vert;
    start       = 1'b1;
    vertical_in = vert;
    t0          = cyc;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, 1);
    if (disturb) begin
      repeat (6) @(negedge clk);
      start       = 1'b1;
      vertical_in = ~vert;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done_seen"}, done, 1);
    // start cycle and done cycle both counted
    check({tag, "_frame_time"}, cyc - t0 + 1, N + L + 3);
    check({tag, "_busy_at_done"}, busy, 0);
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, done_c.size(), 1);
    check({tag, "_nreads"}, rd_a.size(), N);
    check({tag, "_nwrites"}, wr_a.size(), N);
    check({tag, "_vert_stable"}, vert_bad, 0);
    check({tag, "_addr_vertical"}, addr_vertical, vert);
    check({tag, "_fill_count"}, fill_count, exp_fill);
    n = (wr_a.size() < N) ? wr_a.size() : N;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr_addr[%0d]", tag, i), wr_a[i], exp_a[i]);
      check($sformatf("%s_wr_data[%0d]", tag, i), wr_d[i], exp_d[i]);
      if (i < rd_a.size()) begin
        check($sformatf("%s_rd_addr[%0d]", tag, i), rd_a[i], exp_a[i]);
        check($sformatf("%s_latency[%0d]", tag, i), wr_c[i] - rd_c[i], L + 1);
      end
    end
  endtask

  int row0[8] = '{5, 5, 5, 0, 7, 7, 9, 9};
  int col2[4] = '{6, 6, 6, 0};
  int col2a[4] = '{2, 10, 18, 26};

  initial begin
    int k;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_fill_count", fill_count, 0);
    check("rst_addr_vertical", addr_vertical, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed row 0 with holes, row 1 starting with zeros
    fill_random();
    mem[0] = 5; mem[1] = 0; mem[2] = 0; mem[3] = 0;
    mem[4] = 7; mem[5] = 0; mem[6] = 9; mem[7] = 0;
    mem[8] = 0; mem[9] = 0; mem[10] = 3;
    run_frame("h_dir", 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      if (i < wr_d.size()) check($sformatf("row0_val[%0d]", i), wr_d[i], row0[i]);

    // Row 0 ending valid: no carry into row 1
    mem[7] = 9;
    run_frame("h_carry", 1'b0, 1'b0);
    if (wr_d.size() > 9) begin
      check("row1_px0", wr_d[8], 0);
      check("row1_px1", wr_d[9], 0);
    end

    // Vertical pass, column 2 = 6,0,0,0
    fill_random();
    mem[2] = 6; mem[10] = 0; mem[18] = 0; mem[26] = 0;
    run_frame("v_dir", 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      if (8 + i < wr_d.size()) begin
        check($sformatf("col2_addr[%0d]", i), wr_a[8 + i], col2a[i]);
        check($sformatf("col2_val[%0d]", i), wr_d[8 + i], col2[i]);
      end

    // start and vertical_in disturbed during the frame
    fill_random();
    run_frame("disturb", 1'b0, 1'b1);
    vertical_in = 1'b0;

    // Reset mid-frame at pixel 13
    fill_random();
    @(negedge clk);
    clear_mon();
    start = 1'b1;
    vertical_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(rd_en && rd_addr == AW'(13)) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("abort_at13", rd_addr, 13);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_addr_go", addr_go, 0);
    check("abort_wr_en", wr_en, 0);
    check("abort_wr_addr", wr_addr, 0);
    check("abort_wr_data", wr_data, 0);
    check("abort_fill_count", fill_count, 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_c.size(), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    run_frame("after_abort", 1'b0, 1'b0);

    // All-zero and all-nonzero frames
    for (int i = 0; i < N; i++) mem[i] = '0;
    run_frame("all_zero", 1'b0, 1'b0);
    check("all_zero_fill", fill_count, 0);
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom_range(1, 255));
    run_frame("all_valid", 1'b1, 1'b0);
    check("all_valid_fill", fill_count, 0);

    // Random frames, both directions
    for (int f = 0; f < 4; f++) begin
      fill_random();
      run_frame($sformatf("rand%0d", f), f[0], 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
